// File: rtl/cbit_pkg.sv
// cbit_pkg
// Shared definitions for the cbit BRAM support logic.
//  - sweep_state_t : state encoding of the CLOCK victim sweeper FSM.
//  - depth_of()    : table depth (2**l2_depth) from its log2.
package cbit_pkg;

  typedef enum logic [2:0] {
    SWEEP_IDLE  = 3'd0,
    SWEEP_ISSUE = 3'd1,
    SWEEP_WAIT  = 3'd2,
    SWEEP_EVAL  = 3'd3,
    SWEEP_RESP  = 3'd4
  } sweep_state_t;

  function automatic int unsigned depth_of(input int unsigned l2_depth);
    return 32'd1 << l2_depth;
  endfunction

endpackage

// File: rtl/cbit_clock_sweeper.sv
// cbit_clock_sweeper
// CLOCK (second-chance) eviction-victim finder. Walks a persistent hand over
// the cbit table through BRAM port 1 (single-bit, read-and-clear). Set bits
// are cleared as the hand passes; the first entry whose bit was already 0 is
// returned as the victim.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid / req_ready       victim request handshake (ready only in IDLE)
//   victim_valid / victim_ready victim response handshake
//   victim_addr                 selected entry
//   victim_probes               probes used for this victim (1..DEPTH+1)
//   en1, addr1, regce1, rst1    BRAM port-1 controls (addr1 always = hand)
//   dout1                       BRAM port-1 cbit, 2-cycle registered latency
module cbit_clock_sweeper
  import cbit_pkg::*;
#(
  parameter int L2_DEPTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  output logic                victim_valid,
  input  logic                victim_ready,
  output logic [L2_DEPTH-1:0] victim_addr,
  output logic [L2_DEPTH:0]   victim_probes,
  output logic                en1,
  output logic [L2_DEPTH-1:0] addr1,
  output logic                regce1,
  output logic                rst1,
  input  logic                dout1
);

  sweep_state_t          state_reg, state_next;
  logic [L2_DEPTH-1:0]   hand_reg;
  logic [L2_DEPTH:0]     probes_reg;
  logic [L2_DEPTH-1:0]   victim_addr_reg;
  logic [L2_DEPTH:0]     victim_probes_reg;

  // State register plus the hand / probe datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= SWEEP_IDLE;
      hand_reg          <= '0;
      probes_reg        <= '0;
      victim_addr_reg   <= '0;
      victim_probes_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        SWEEP_IDLE: begin
          if (req_valid) begin
            probes_reg <= '0;
          end
        end
        SWEEP_ISSUE: begin
          probes_reg <= probes_reg + (L2_DEPTH+1)'(1);
        end
        SWEEP_EVAL: begin
          // The hand moves past the probed entry either way; a set bit has
          // just been cleared by the read, a clear bit makes it the victim.
          hand_reg <= hand_reg + L2_DEPTH'(1);
          if (!dout1) begin
            victim_addr_reg   <= hand_reg;
            victim_probes_reg <= probes_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic. A full sweep clears every bit, so the search always
  // terminates within DEPTH+1 probes and needs no timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SWEEP_IDLE:  if (req_valid)    state_next = SWEEP_ISSUE;
      SWEEP_ISSUE:                   state_next = SWEEP_WAIT;
      SWEEP_WAIT:                    state_next = SWEEP_EVAL;
      SWEEP_EVAL:  state_next = dout1 ? SWEEP_ISSUE : SWEEP_RESP;
      SWEEP_RESP:  if (victim_ready) state_next = SWEEP_IDLE;
      default:                       state_next = SWEEP_IDLE;
    endcase
  end

  assign req_ready     = (state_reg == SWEEP_IDLE);
  assign victim_valid  = (state_reg == SWEEP_RESP);
  assign victim_addr   = victim_addr_reg;
  assign victim_probes = victim_probes_reg;
  assign en1           = (state_reg == SWEEP_ISSUE);
  assign addr1         = hand_reg;
  assign regce1        = 1'b1;
  assign rst1          = 1'b0;

endmodule

// File: tb/tb_cbit_clock_sweeper.sv
// tb_cbit_clock_sweeper
// Self-checking bench for cbit_clock_sweeper with L2_DEPTH=3 and a behavioural
// read-and-clear BRAM port model. Expected victims, probe counts, latencies and
// post-search cbit contents come from a plain second-chance search model.
module tb_cbit_clock_sweeper;

  localparam int L2    = 3;
  localparam int DEPTH = int'(cbit_pkg::depth_of(L2));

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          victim_valid;
  logic          victim_ready = 1'b0;
  logic [L2-1:0] victim_addr;
  logic [L2:0]   victim_probes;
  logic          en1;
  logic [L2-1:0] addr1;
  logic          regce1;
  logic          rst1;
  logic          dout1 = 1'b0;

  int checks = 0;
  int passed = 0;

  // Bench-side model state.
  logic [DEPTH-1:0] model_bits = '0;
  int               model_hand = 0;

  // Behavioural BRAM port 1: read-and-clear, output register + regce stage.
  logic [DEPTH-1:0] mem = '0;
  logic             stage1 = 1'b0;
  logic             load_req = 1'b0;
  logic [DEPTH-1:0] load_val = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) begin
      mem <= load_val;
    end else if (en1) begin
      stage1     <= mem[addr1];
      mem[addr1] <= 1'b0;
    end
    if (regce1) dout1 <= rst1 ? 1'b0 : stage1;
  end

  cbit_clock_sweeper #(.L2_DEPTH(L2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .victim_valid (victim_valid),
    .victim_ready (victim_ready),
    .victim_addr  (victim_addr),
    .victim_probes(victim_probes),
    .en1          (en1),
    .addr1        (addr1),
    .regce1       (regce1),
    .rst1         (rst1),
    .dout1        (dout1)
  );

  // Second-chance search over a plain bit vector.
  task automatic model_search(inout logic [DEPTH-1:0] bits, inout int hand,
                              output int victim, output int probes);
    victim = -1;
    probes = 0;
    for (int n = 0; n <= DEPTH; n++) begin
      probes++;
      if (bits[hand]) begin
        bits[hand] = 1'b0;
        hand = (hand + 1) % DEPTH;
      end else begin
        victim = hand;
        hand = (hand + 1) % DEPTH;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid    = 1'b0;
    victim_ready = 1'b0;
    resetn       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn     = 1'b1;
    model_hand = 0;
  endtask

  task automatic load_bits(input logic [DEPTH-1:0] v);
    @(negedge clk);
    load_val = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req   = 1'b0;
    model_bits = v;
  endtask

  // One request/response transaction checked against the model.
  task automatic run_req(input int hold, input string tag,
                         output int got_victim, output int got_probes);
    logic [DEPTH-1:0] bits_exp;
    int hand_exp, vic, prb, lat, en_cnt;
    logic [L2-1:0] held_addr;
    logic [L2:0]   held_probes;
    bits_exp = model_bits;
    hand_exp = model_hand;
    model_search(bits_exp, hand_exp, vic, prb);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle got %b want 1", tag, req_ready);
    else passed++;
    req_valid    = 1'b1;
    victim_ready = (hold == 0);
    @(posedge clk);
    lat    = 0;
    en_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (en1) en_cnt++;
    end while (!victim_valid && lat < 3 * (DEPTH + 1) + 10);

    checks++;
    if (!victim_valid) $display("FAIL %s timeout got victim_valid=0 after %0d cycles want 1", tag, lat);
    else passed++;
    checks++;
    if (lat !== 3 * prb + 1) $display("FAIL %s latency got %0d want %0d", tag, lat, 3 * prb + 1);
    else passed++;
    checks++;
    if (en_cnt !== prb) $display("FAIL %s en1_pulses got %0d want %0d", tag, en_cnt, prb);
    else passed++;
    checks++;
    if (victim_addr !== L2'(vic)) $display("FAIL %s victim_addr got %0d want %0d", tag, victim_addr, vic);
    else passed++;
    checks++;
    if (victim_probes !== (L2+1)'(prb)) $display("FAIL %s victim_probes got %0d want %0d", tag, victim_probes, prb);
    else passed++;
    got_victim  = int'(victim_addr);
    got_probes  = int'(victim_probes);
    held_addr   = victim_addr;
    held_probes = victim_probes;

    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (victim_valid !== 1'b1 || victim_addr !== held_addr || victim_probes !== held_probes ||
            req_ready !== 1'b0 || en1 !== 1'b0)
          $display("FAIL %s hold_stable cyc %0d got v=%b a=%0d p=%0d rdy=%b en1=%b want v=1 a=%0d p=%0d rdy=0 en1=0",
                   tag, i, victim_valid, victim_addr, victim_probes, req_ready, en1, held_addr, held_probes);
        else passed++;
        req_valid = 1'b1;  // must be ignored outside IDLE
      end
      @(negedge clk);
      req_valid    = 1'b0;
      victim_ready = 1'b1;
    end

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || victim_valid !== 1'b0 || en1 !== 1'b0)
      $display("FAIL %s back_to_idle got rdy=%b v=%b en1=%b want rdy=1 v=0 en1=0", tag, req_ready, victim_valid, en1);
    else passed++;
    victim_ready = 1'b0;
    checks++;
    if (addr1 !== L2'(hand_exp)) $display("FAIL %s next_hand got %0d want %0d", tag, addr1, hand_exp);
    else passed++;
    checks++;
    if (mem !== bits_exp) $display("FAIL %s cbits got %b want %b", tag, mem, bits_exp);
    else passed++;

    model_bits = bits_exp;
    model_hand = hand_exp;
    $display("txn %-10s victim=%0d probes=%0d latency=%0d hand=%0d cbits=%b",
             tag, got_victim, got_probes, lat, addr1, mem);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (victim_valid !== 1'b0 || victim_addr !== '0 || victim_probes !== '0 || en1 !== 1'b0 || addr1 !== '0)
      $display("FAIL reset_outputs got v=%b a=%0d p=%0d en1=%b addr1=%0d want all 0",
               victim_valid, victim_addr, victim_probes, en1, addr1);
    else passed++;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || regce1 !== 1'b1 || rst1 !== 1'b0)
      $display("FAIL reset_ready got rdy=%b regce1=%b rst1=%b want 1 1 0", req_ready, regce1, rst1);
    else passed++;
  endtask

  task automatic test_all_zero();
    int v, p;
    apply_reset();
    load_bits(8'h00);
    run_req(0, "allzero1", v, p);
    checks++;
    if (v !== 0 || p !== 1) $display("FAIL allzero1_const got %0d/%0d want 0/1", v, p);
    else passed++;
    run_req(0, "allzero2", v, p);
    checks++;
    if (v !== 1 || p !== 1) $display("FAIL allzero2_const got %0d/%0d want 1/1", v, p);
    else passed++;
  endtask

  task automatic test_prefix();
    int v, p;
    apply_reset();
    load_bits(8'b0000_0111);
    run_req(0, "prefix", v, p);
    checks++;
    if (v !== 3 || p !== 4) $display("FAIL prefix_const got %0d/%0d want 3/4", v, p);
    else passed++;
  endtask

  task automatic test_full_sweep();
    int v, p;
    apply_reset();
    load_bits(8'hFF);
    run_req(0, "fullsweep", v, p);
    checks++;
    if (v !== 0 || p !== 9 || mem !== 8'h00) $display("FAIL fullsweep_const got %0d/%0d bits=%b want 0/9 bits=0", v, p, mem);
    else passed++;
  endtask

  task automatic test_wrap();
    int v, p;
    apply_reset();
    load_bits(8'b0011_1111);     // victim 6, hand lands on 7
    run_req(0, "to_hand7", v, p);
    load_bits(8'b1000_0000);     // cbit7=1, cbit0=0
    run_req(0, "wrap", v, p);
    checks++;
    if (v !== 0 || p !== 2 || addr1 !== 3'd1) $display("FAIL wrap_const got %0d/%0d hand=%0d want 0/2 hand=1", v, p, addr1);
    else passed++;
  endtask

  task automatic test_backpressure();
    int v, p;
    load_bits(8'b0101_1010);
    run_req(5, "backpress", v, p);
  endtask

  task automatic test_reset_mid_search();
    int v, p;
    apply_reset();
    load_bits(8'hFF);
    @(negedge clk);
    req_valid    = 1'b1;
    victim_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == 7) begin
        checks++;
        if (en1 !== 1'b1 || addr1 !== 3'd2) $display("FAIL midreset_probe3 got en1=%b addr1=%0d want 1 2", en1, addr1);
        else passed++;
      end
    end
    resetn = 1'b0;               // WAIT of probe 3
    #1;
    checks++;
    if (en1 !== 1'b0 || victim_valid !== 1'b0 || addr1 !== '0 || victim_probes !== '0)
      $display("FAIL midreset_async got en1=%b v=%b hand=%0d p=%0d want 0 0 0 0", en1, victim_valid, addr1, victim_probes);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    resetn       = 1'b1;
    victim_ready = 1'b0;
    model_hand   = 0;
    model_bits   = 8'b1111_1000; // probes 1..3 already cleared their bits
    checks++;
    if (mem !== model_bits) $display("FAIL midreset_cbits got %b want %b", mem, model_bits);
    else passed++;
    run_req(0, "after_rst", v, p);
    checks++;
    if (v !== 0 || p !== 1) $display("FAIL after_rst_const got %0d/%0d want 0/1", v, p);
    else passed++;
  endtask

  task automatic test_random();
    int v, p;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) load_bits(DEPTH'($urandom));
      run_req(int'($urandom_range(0, 3)), $sformatf("rand%0d", i), v, p);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_prefix();
    test_full_sweep();
    test_wrap();
    test_backpressure();
    test_reset_mid_search();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
